// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the execute stage and the multi-cycle RV32M unit.
// The master side issues operations; the slave side is the sequencer.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32,
    parameter int OPW  = 6
);
    logic            start;
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, operand1, operand2, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, op, operand1, operand2, flush,
        output busy, stall, done, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M unit: registered two-cycle multiply, restoring radix-2 divide,
// one operation at a time behind a start/busy/done handshake.
module muldiv_sequencer #(
    parameter int XLEN = 32,
    parameter int OPW  = 6
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t          state_reg;
    logic [2:0]      op_reg;
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic            sign_a_reg;
    logic            sign_b_reg;
    logic [XLEN-1:0] dvd_reg;
    logic [XLEN-1:0] dvs_reg;
    logic [XLEN-1:0] rem_reg;
    logic [CW-1:0]   count_reg;
    logic [XLEN-1:0] result_reg;
    logic            busy_reg;
    logic            done_reg;

    // Acceptance-side decode
    logic            op_valid;
    logic            in_signed;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_result;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    always_comb begin
        op_valid       = (bus.op[OPW-1:3] == (OPW-3)'(2));
        in_signed      = ~bus.op[0];
        div_zero       = (bus.operand2 == '0);
        div_ovf        = in_signed && (bus.operand1 == MIN_INT) && (bus.operand2 == '1);
        special_result = div_zero ? (bus.op[1] ? bus.operand1 : '1)
                                  : (bus.op[1] ? '0 : MIN_INT);
        // Negating MIN_INT yields MIN_INT, which is exactly 2^31 read as unsigned.
        mag_a = (in_signed && bus.operand1[XLEN-1]) ? -bus.operand1 : bus.operand1;
        mag_b = (in_signed && bus.operand2[XLEN-1]) ? -bus.operand2 : bus.operand2;
    end

    // Multiply: 33-bit sign/zero-extended operands; low 64 bits of the product are exact
    logic signed [XLEN:0]     mul_a;
    logic signed [XLEN:0]     mul_b;
    logic signed [2*XLEN-1:0] product;
    logic [XLEN-1:0]          mul_sel;

    always_comb begin
        mul_a   = {(op_reg[1] ^ op_reg[0]) & a_reg[XLEN-1], a_reg};
        mul_b   = {(~op_reg[1] & op_reg[0]) & b_reg[XLEN-1], b_reg};
        product = (2*XLEN)'(mul_a) * (2*XLEN)'(mul_b);
        mul_sel = (op_reg[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end

    // One restoring step; a borrow out of the 33-bit subtract means rem < divisor
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   rem_sub;
    logic            q_bit;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fix_result;

    always_comb begin
        rem_shift  = {rem_reg, dvd_reg[XLEN-1]};
        rem_sub    = rem_shift - {1'b0, dvs_reg};
        q_bit      = ~rem_sub[XLEN];
        rem_next   = q_bit ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
        quot_fix   = (~op_reg[0] && (sign_a_reg ^ sign_b_reg)) ? -dvd_reg : dvd_reg;
        rem_fix    = (~op_reg[0] && sign_a_reg) ? -rem_reg : rem_reg;
        fix_result = op_reg[1] ? rem_fix : quot_fix;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            rem_reg    <= '0;
            count_reg  <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (bus.flush) begin
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
                count_reg <= '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (bus.start && op_valid) begin
                            op_reg     <= bus.op[2:0];
                            a_reg      <= bus.operand1;
                            b_reg      <= bus.operand2;
                            sign_a_reg <= bus.operand1[XLEN-1];
                            sign_b_reg <= bus.operand2[XLEN-1];
                            busy_reg   <= 1'b1;
                            if (!bus.op[2]) begin
                                state_reg <= S_MUL;
                            end else if (div_zero || div_ovf) begin
                                result_reg <= special_result;
                                done_reg   <= 1'b1;
                                state_reg  <= S_DONE;
                            end else begin
                                dvd_reg   <= mag_a;
                                dvs_reg   <= mag_b;
                                rem_reg   <= '0;
                                count_reg <= CW'(XLEN-1);
                                state_reg <= S_DIV;
                            end
                        end
                    end
                    S_MUL: begin
                        result_reg <= mul_sel;
                        done_reg   <= 1'b1;
                        state_reg  <= S_DONE;
                    end
                    S_DIV: begin
                        // dvd_reg doubles as the quotient: bits shift in at the bottom
                        dvd_reg   <= {dvd_reg[XLEN-2:0], q_bit};
                        rem_reg   <= rem_next;
                        count_reg <= count_reg - 1'b1;
                        if (count_reg == '0) begin
                            state_reg <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        result_reg <= fix_result;
                        done_reg   <= 1'b1;
                        state_reg  <= S_DONE;
                    end
                    S_DONE: begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                    default: begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
    assign bus.stall  = busy_reg | (bus.start & op_valid);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboarded bench for muldiv_sequencer: directed cases plus random operations
// checked against an arithmetic reference model for result and done cycle.
module tb_muldiv_sequencer;
    localparam logic [5:0] OP_MUL    = 6'b010000;
    localparam logic [5:0] OP_MULH   = 6'b010001;
    localparam logic [5:0] OP_MULHSU = 6'b010010;
    localparam logic [5:0] OP_MULHU  = 6'b010011;
    localparam logic [5:0] OP_DIV    = 6'b010100;
    localparam logic [5:0] OP_DIVU   = 6'b010101;
    localparam logic [5:0] OP_REM    = 6'b010110;
    localparam logic [5:0] OP_REMU   = 6'b010111;
    localparam logic [31:0] MIN_INT  = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] last_res = '0;

    typedef struct {
        logic [31:0] res;
        int          due;
        logic [5:0]  op;
    } exp_t;
    exp_t sb_q[$];

    muldiv_sequencer_if #(.XLEN(32), .OPW(6)) bus ();

    muldiv_sequencer #(.XLEN(32), .OPW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end else begin
            $display("ok   %s cycle=%0d value=%h", name, cyc, act);
        end
    endtask

    function automatic logic [31:0] model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          ps;
        longint unsigned pu;
        int              ia;
        int              ib;
        ia = a;
        ib = b;
        case (o)
            OP_MUL:    begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
            OP_MULH:   begin sa = ia; sb = ib; ps = sa * sb; return ps[63:32]; end
            OP_MULHSU: begin sa = ia; sb = {32'b0, b}; ps = sa * sb; return ps[63:32]; end
            OP_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            OP_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
                return 32'(ia / ib);
            end
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    begin
                if (b == 0) return a;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o < OP_DIV) return 2;
        if (b == 0) return 1;
        if ((o == OP_DIV || o == OP_REM) && a == MIN_INT && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic bit valid_op(input logic [5:0] o);
        return (o >= OP_MUL) && (o <= OP_REMU);
    endfunction

    task automatic push_expect(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b, input int due);
        exp_t e;
        e.res = model(o, a, b);
        e.due = due;
        e.op  = o;
        sb_q.push_back(e);
    endtask

    // Called at a falling edge with the unit idle; returns one cycle later
    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b, input bit track);
        bus.start    = 1'b1;
        bus.op       = o;
        bus.operand1 = a;
        bus.operand2 = b;
        if (track && valid_op(o)) push_expect(o, a, b, cyc + latency(o, a, b));
        #1;
        check("stall_on_start", {31'b0, bus.stall}, {31'b0, valid_op(o)});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 100; k++) begin
            if (!bus.busy && sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (k == 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout cycle=%0d got busy=%0b pending=%0d expected idle", cyc, bus.busy, sb_q.size());
        end
    endtask

    // Monitor: every done pulse pops one expectation
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done cycle=%0d got result=%h expected no done", cyc, bus.result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("result_op%b", e.op), bus.result, e.res);
                check("done_cycle", 32'(cyc), 32'(e.due));
                last_res = e.res;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d got no finish expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [5:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        reset = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0;
        bus.operand1 = '0; bus.operand2 = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   {31'b0, bus.busy},  32'h0);
        check("reset_done",   {31'b0, bus.done},  32'h0);
        check("reset_stall",  {31'b0, bus.stall}, 32'h0);
        check("reset_result", bus.result,         32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Multiply and divide directed cases
        issue(OP_MULH,   32'hFFFF_FFFE, 32'd3,         1); wait_idle();
        issue(OP_MUL,    32'hFFFF_FFFE, 32'd3,         1); wait_idle();
        issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_idle();
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_idle();
        issue(OP_DIV,    32'hFFFF_FFF9, 32'd2,         1); wait_idle();
        issue(OP_REM,    32'hFFFF_FFF9, 32'd2,         1); wait_idle();
        issue(OP_DIVU,   32'hFFFF_FFF9, 32'd2,         1); wait_idle();
        issue(OP_REMU,   32'hFFFF_FFF9, 32'd2,         1); wait_idle();
        issue(OP_DIVU,   32'd5,         32'd0,         1); wait_idle();
        issue(OP_REMU,   32'd5,         32'd0,         1); wait_idle();
        issue(OP_DIV,    MIN_INT,       32'hFFFF_FFFF, 1); wait_idle();
        issue(OP_REM,    MIN_INT,       32'hFFFF_FFFF, 1); wait_idle();
        issue(OP_DIV,    MIN_INT,       32'd1,         1); wait_idle();
        issue(OP_REM,    32'd7,         32'hFFFF_FFFE, 1); wait_idle();

        // Reset during a division at cycle 15
        issue(OP_DIV, 32'd1000, 32'd3, 0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_busy",   {31'b0, bus.busy}, 32'h0);
        check("rst_mid_done",   {31'b0, bus.done}, 32'h0);
        check("rst_mid_result", bus.result,        32'h0);
        reset = 1'b0;
        last_res = '0;
        issue(OP_DIVU, 32'd1000, 32'd3, 1); wait_idle();

        // Flush at cycle 10 of a division; result must hold
        issue(OP_DIV, 32'd100, 32'd7, 0);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy",   {31'b0, bus.busy}, 32'h0);
        check("flush_done",   {31'b0, bus.done}, 32'h0);
        check("flush_result", bus.result,        last_res);
        issue(OP_MUL, 32'd6, 32'd7, 1); wait_idle();

        // Back-to-back with start held high; op changes while busy are ignored
        c0 = cyc;
        bus.start = 1'b1; bus.op = OP_DIV; bus.operand1 = 32'd100; bus.operand2 = 32'd7;
        push_expect(OP_DIV, 32'd100, 32'd7, c0 + 34);
        @(negedge clk);
        bus.op = OP_REM;
        push_expect(OP_REM, 32'd100, 32'd7, c0 + 69);
        for (int k = 1; k <= 69; k++) begin
            check("b2b_stall", {31'b0, bus.stall}, 32'h1);
            if (k == 36) bus.start = 1'b0;
            @(negedge clk);
        end
        check("b2b_stall_drop", {31'b0, bus.stall}, 32'h0);
        check("b2b_busy_drop",  {31'b0, bus.busy},  32'h0);
        wait_idle();

        // Random operations, including invalid codes and special divisors
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                o = 6'($urandom_range(0, 63));
                if (valid_op(o)) o = o + 6'd8;
            end else begin
                o = OP_MUL + 6'($urandom_range(0, 7));
            end
            case ($urandom_range(0, 5))
                0:       begin a = $urandom; b = 32'h0; end
                1:       begin a = MIN_INT; b = 32'hFFFF_FFFF; end
                2:       begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            issue(o, a, b, 1);
            if (!valid_op(o)) begin
                check("invalid_busy", {31'b0, bus.busy}, 32'h0);
                repeat (3) @(negedge clk);
            end
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
